// File: rtl/axis_router_pkg.sv
// Shared register map, bit positions and FSM encoding
// for the AXI-Stream engine router.
package axis_router_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_LEN    = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_SEL_LSB = 8;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR_SEL = 2;
  localparam int ST_ERR_LEN = 3;
  localparam int ST_CNT_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry registered stream buffer with flush.
// Ports: clk/resetn/flush, in_* (sink), out_* (source).
module axis_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] dat0_q, dat0_d;
  logic [DATA_W-1:0] dat1_q, dat1_d;
  logic              lst0_q, lst0_d;
  logic              lst1_q, lst1_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push, pop;

  // Ready comes from the registered fill level only,
  // so no combinational path runs back from out_ready.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = rptr_q ? dat1_q : dat0_q;
  assign out_last  = out_valid &
                     (rptr_q ? lst1_q : lst0_q);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    lst0_d = lst0_q;
    lst1_d = lst1_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      if (wptr_q) begin
        dat1_d = in_data;
        lst1_d = in_last;
      end else begin
        dat0_d = in_data;
        lst0_d = in_last;
      end
      wptr_d = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (flush) begin
      cnt_d  = 2'd0;
      wptr_d = 1'b0;
      rptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dat0_q <= '0;
      dat1_q <= '0;
      lst0_q <= 1'b0;
      lst1_q <= 1'b0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
      lst0_q <= lst0_d;
      lst1_q <= lst1_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_engine_router.sv
// Routes one VDMA stream to a selected engine and returns
// its results; APB regs CTRL/LEN/STATUS control each job.
module axis_engine_router
  import axis_router_pkg::*;
#(
  parameter int NUM_ENG = 3,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [31:0]               PADDR,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [31:0]               PWDATA,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [DATA_W-1:0]         S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0]       S_AXIS_TKEEP,
  input  logic                      S_AXIS_TLAST,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  output logic [DATA_W-1:0]         M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]       M_AXIS_TKEEP,
  output logic                      M_AXIS_TLAST,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [NUM_ENG*DATA_W-1:0] ENG_TX_TDATA,
  output logic [NUM_ENG-1:0]        ENG_TX_TLAST,
  output logic [NUM_ENG-1:0]        ENG_TX_TVALID,
  input  logic [NUM_ENG-1:0]        ENG_TX_TREADY,
  input  logic [NUM_ENG*DATA_W-1:0] ENG_RX_TDATA,
  input  logic [NUM_ENG-1:0]        ENG_RX_TLAST,
  input  logic [NUM_ENG-1:0]        ENG_RX_TVALID,
  output logic [NUM_ENG-1:0]        ENG_RX_TREADY
);

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        csel_q, csel_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              done_q, done_d;
  logic              esel_q, esel_d;
  logic              elen_q, elen_d;
  logic              set_done, set_esel, set_elen;
  logic              acc, wr, rd, mapped;
  logic              wr_ctrl, start, abort;
  logic              busy, run, flush, m_hs, last_beat;
  logic              sel_ok;
  logic [3:0]        addr;
  logic [2:0]        wr_sel, clr;
  logic [31:0]       status, rdata;
  logic              sk_valid, sk_ready, sk_last;
  logic [DATA_W-1:0] sk_data;
  logic              unused_ok;

  assign unused_ok = ^{S_AXIS_TKEEP, PADDR, PWDATA};

  assign addr    = PADDR[3:0];
  assign acc     = PSEL & PENABLE;
  assign wr      = acc & PWRITE;
  assign rd      = acc & ~PWRITE;
  assign mapped  = (addr == ADDR_CTRL) |
                   (addr == ADDR_LEN) |
                   (addr == ADDR_STATUS);
  assign wr_ctrl = wr & (addr == ADDR_CTRL);
  assign start   = wr_ctrl & PWDATA[CTRL_START];
  assign abort   = wr_ctrl & PWDATA[CTRL_ABORT];
  assign wr_sel  = PWDATA[CTRL_SEL_LSB +: 3];
  assign sel_ok  = {1'b0, wr_sel} < 4'(NUM_ENG);
  assign clr     = (wr & (addr == ADDR_STATUS)) ?
                   PWDATA[3:1] : 3'b000;
  assign busy    = (state_q != S_IDLE);
  assign run     = (state_q == S_RUN);
  assign m_hs    = M_AXIS_TVALID & M_AXIS_TREADY;
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign last_beat = (cnt_inc == len_q);

  assign PREADY  = 1'b1;
  // A START that arrives with ABORT is dropped, not an error.
  assign PSLVERR = acc & (~mapped |
                   (start & ~abort & busy));
  assign PRDATA  = (rd & mapped) ? rdata : 32'd0;
  assign M_AXIS_TKEEP = '1;

  always_comb begin
    status = '0;
    status[ST_BUSY]    = busy;
    status[ST_DONE]    = done_q;
    status[ST_ERR_SEL] = esel_q;
    status[ST_ERR_LEN] = elen_q;
    status[ST_CNT_LSB +: LEN_W] = cnt_q;
    rdata = '0;
    unique case (1'b1)
      (addr == ADDR_CTRL):
        rdata[CTRL_SEL_LSB +: 3] = csel_q;
      (addr == ADDR_LEN):
        rdata[LEN_W-1:0] = len_q;
      (addr == ADDR_STATUS):
        rdata = status;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    csel_d   = csel_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    flush    = 1'b0;
    set_done = 1'b0;
    set_esel = 1'b0;
    set_elen = 1'b0;
    if (wr_ctrl) csel_d = wr_sel;
    if (wr & (addr == ADDR_LEN))
      len_d = PWDATA[LEN_W-1:0];
    unique case (state_q)
      S_IDLE: begin
        if (start & ~abort) begin
          if (sel_ok & (len_q != '0)) begin
            state_d = S_RUN;
            cnt_d   = '0;
            sel_d   = wr_sel;
          end else begin
            set_esel = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (m_hs) begin
          cnt_d = cnt_inc;
          if (last_beat) state_d = S_DONE;
          // TLAST must mark exactly the LEN-th beat.
          if (last_beat != M_AXIS_TLAST)
            set_elen = 1'b1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        set_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (done_q & ~clr[0]) | set_done;
    esel_d = (esel_q & ~clr[1]) | set_esel;
    elen_d = (elen_q & ~clr[2]) | set_elen;
  end

  always_comb begin
    ENG_TX_TDATA  = '0;
    ENG_TX_TLAST  = '0;
    ENG_TX_TVALID = '0;
    ENG_RX_TREADY = '0;
    S_AXIS_TREADY = 1'b0;
    sk_valid      = 1'b0;
    sk_last       = 1'b0;
    sk_data       = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (run && (sel_q == 3'(i))) begin
        ENG_TX_TDATA[i*DATA_W +: DATA_W] =
          S_AXIS_TDATA;
        ENG_TX_TLAST[i]  = S_AXIS_TLAST;
        ENG_TX_TVALID[i] = S_AXIS_TVALID;
        S_AXIS_TREADY    = ENG_TX_TREADY[i];
        sk_valid = ENG_RX_TVALID[i];
        sk_last  = ENG_RX_TLAST[i];
        sk_data  = ENG_RX_TDATA[i*DATA_W +: DATA_W];
        ENG_RX_TREADY[i] = sk_ready;
      end
    end
  end

  axis_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk       (CLK),
    .resetn    (RESETN),
    .flush     (flush),
    .in_data   (sk_data),
    .in_last   (sk_last),
    .in_valid  (sk_valid),
    .in_ready  (sk_ready),
    .out_data  (M_AXIS_TDATA),
    .out_last  (M_AXIS_TLAST),
    .out_valid (M_AXIS_TVALID),
    .out_ready (M_AXIS_TREADY)
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      csel_q  <= 3'd0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      esel_q  <= 1'b0;
      elen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      csel_q  <= csel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      esel_q  <= esel_d;
      elen_q  <= elen_d;
    end
  end

endmodule

// File: tb/tb_axis_engine_router.sv
// Scoreboard bench for axis_engine_router: engine beats
// are queued on acceptance and matched at M_AXIS.
module tb_axis_engine_router;

  localparam int NE = 3;
  localparam int DW = 32;
  localparam int LW = 16;

  logic           CLK = 1'b0;
  logic           RESETN = 1'b0;
  logic [31:0]    PADDR = '0;
  logic           PSEL = 1'b0;
  logic           PENABLE = 1'b0;
  logic           PWRITE = 1'b0;
  logic [31:0]    PWDATA = '0;
  logic [31:0]    PRDATA;
  logic           PREADY;
  logic           PSLVERR;
  logic [DW-1:0]  S_AXIS_TDATA = '0;
  logic [DW/8-1:0] S_AXIS_TKEEP = '1;
  logic           S_AXIS_TLAST = 1'b0;
  logic           S_AXIS_TVALID = 1'b0;
  logic           S_AXIS_TREADY;
  logic [DW-1:0]  M_AXIS_TDATA;
  logic [DW/8-1:0] M_AXIS_TKEEP;
  logic           M_AXIS_TLAST;
  logic           M_AXIS_TVALID;
  logic           M_AXIS_TREADY = 1'b0;
  logic [NE*DW-1:0] ENG_TX_TDATA;
  logic [NE-1:0]  ENG_TX_TLAST;
  logic [NE-1:0]  ENG_TX_TVALID;
  logic [NE-1:0]  ENG_TX_TREADY = '0;
  logic [NE*DW-1:0] ENG_RX_TDATA = '0;
  logic [NE-1:0]  ENG_RX_TLAST = '0;
  logic [NE-1:0]  ENG_RX_TVALID = '0;
  logic [NE-1:0]  ENG_RX_TREADY;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    chk_lat = 1'b0;
  int    rdy_mode = 0;

  axis_engine_router #(
    .NUM_ENG(NE), .DATA_W(DW), .LEN_W(LW)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR),
    .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TKEEP(S_AXIS_TKEEP),
    .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .ENG_TX_TDATA(ENG_TX_TDATA),
    .ENG_TX_TLAST(ENG_TX_TLAST),
    .ENG_TX_TVALID(ENG_TX_TVALID),
    .ENG_TX_TREADY(ENG_TX_TREADY),
    .ENG_RX_TDATA(ENG_RX_TDATA),
    .ENG_RX_TLAST(ENG_RX_TLAST),
    .ENG_RX_TVALID(ENG_RX_TVALID),
    .ENG_RX_TREADY(ENG_RX_TREADY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // 0: always ready, 1: toggle 1010..., 2: held low
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0: M_AXIS_TREADY = 1'b1;
      1: M_AXIS_TREADY = ~M_AXIS_TREADY;
      default: M_AXIS_TREADY = 1'b0;
    endcase
  end

  always @(negedge CLK) begin : mon
    beat_t e;
    if (RESETN && M_AXIS_TVALID && M_AXIS_TREADY) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", M_AXIS_TDATA, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("m_data", M_AXIS_TDATA, e.data);
        check("m_last", 32'(M_AXIS_TLAST),
              32'(e.last));
        check("m_keep", 32'(M_AXIS_TKEEP), 32'hF);
        if (chk_lat)
          check("m_latency", 32'(cyc - e.cyc), 32'd1);
      end
    end
  end

  task automatic apb(input logic wr,
                     input logic [31:0] addr,
                     input logic [31:0] data,
                     output logic [31:0] rdata,
                     output logic err);
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = addr; PWDATA = data;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    @(negedge CLK);
    rdata = PRDATA;
    err = PSLVERR;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input string tag,
                    input logic [31:0] addr,
                    input logic [31:0] data,
                    input int exp_err);
    logic [31:0] rd;
    logic er;
    apb(1'b1, addr, data, rd, er);
    if (exp_err >= 0) check(tag, 32'(er), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] addr,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic er;
    apb(1'b0, addr, 32'd0, rd, er);
    check(tag, rd, exp);
  endtask

  task automatic send(input int sel, input int n,
                      input int last_at,
                      input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      bit ok;
      ENG_RX_TDATA[sel*DW +: DW] = base + 32'(k);
      ENG_RX_TLAST[sel] = (k + 1 == last_at);
      ENG_RX_TVALID[sel] = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge CLK);
        if (ENG_RX_TREADY[sel]) begin
          exp_q.push_back('{data: base + 32'(k),
                            last: (k + 1 == last_at),
                            cyc: cyc});
          ok = 1'b1;
        end
        @(posedge CLK); #1;
      end
      if (!ok) check("eng_accept_timeout", 0, 1);
    end
    ENG_RX_TVALID[sel] = 1'b0;
    ENG_RX_TLAST[sel] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_m_valid", 32'(M_AXIS_TVALID), 0);
    check("rst_m_last", 32'(M_AXIS_TLAST), 0);
    check("rst_s_ready", 32'(S_AXIS_TREADY), 0);
    check("rst_tx_valid", 32'(ENG_TX_TVALID), 0);
    check("rst_rx_ready", 32'(ENG_RX_TREADY), 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_pslverr", 32'(PSLVERR), 0);
    check("pready", 32'(PREADY), 1);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    rd_chk("rst_status", 32'h8, 32'h0);
    rd_chk("rst_len", 32'h4, 32'h0);
    rd_chk("unmapped_rd", 32'hC, 32'h0);
    wr("unmapped_err", 32'hC, 32'h1, 1);

    // sel 1, 8 beats, continuous ready
    wr("len8_err", 32'h4, 32'd8, 0);
    wr("start1_err", 32'h0, 32'h101, 0);
    S_AXIS_TDATA = 32'hA5A5_0001;
    S_AXIS_TLAST = 1'b1;
    S_AXIS_TVALID = 1'b1;
    ENG_TX_TREADY = 3'b010;
    #1;
    check("tx_valid", 32'(ENG_TX_TVALID), 32'h2);
    check("tx_data1", ENG_TX_TDATA[63:32],
          32'hA5A5_0001);
    check("tx_last", 32'(ENG_TX_TLAST), 32'h2);
    check("s_ready_on", 32'(S_AXIS_TREADY), 1);
    ENG_TX_TREADY = 3'b101;
    #1;
    check("s_ready_off", 32'(S_AXIS_TREADY), 0);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST = 1'b0;
    chk_lat = 1'b1;
    send(1, 8, 8, 32'h1000);
    drain("job1_drain");
    chk_lat = 1'b0;
    rd_chk("job1_status", 32'h8, 32'h0008_0002);
    rd_chk("ctrl_sel", 32'h0, 32'h100);
    wr("w1c_done", 32'h8, 32'h2, 0);
    rd_chk("done_clr", 32'h8, 32'h0008_0000);

    // invalid sel, then zero length
    S_AXIS_TVALID = 1'b1;
    wr("bad_sel", 32'h0, 32'h501, -1);
    check("bad_tx_valid", 32'(ENG_TX_TVALID), 0);
    check("bad_s_ready", 32'(S_AXIS_TREADY), 0);
    S_AXIS_TVALID = 1'b0;
    rd_chk("err_sel", 32'h8, 32'h0008_0004);
    wr("w1c_esel", 32'h8, 32'h4, 0);
    wr("len0", 32'h4, 32'd0, 0);
    wr("start_len0", 32'h0, 32'h001, -1);
    rd_chk("err_len0", 32'h8, 32'h0008_0004);
    wr("w1c_esel2", 32'h8, 32'h4, 0);

    // early TLAST
    wr("len4", 32'h4, 32'd4, 0);
    wr("start0", 32'h0, 32'h001, 0);
    send(0, 4, 3, 32'h2000);
    drain("elen_drain");
    rd_chk("err_len", 32'h8, 32'h0004_000A);
    wr("w1c_all", 32'h8, 32'hE, 0);
    rd_chk("all_clr", 32'h8, 32'h0004_0000);

    // toggling backpressure
    rdy_mode = 1;
    wr("len16", 32'h4, 32'd16, 0);
    wr("start2", 32'h0, 32'h201, 0);
    send(2, 16, 16, 32'h3000);
    drain("tog_drain");
    rdy_mode = 0;
    rd_chk("tog_status", 32'h8, 32'h0010_0002);
    wr("w1c_tog", 32'h8, 32'h2, 0);

    // abort after 3 beats with 2 more buffered
    wr("len10", 32'h4, 32'd10, 0);
    wr("start_ab", 32'h0, 32'h001, 0);
    wr("start_busy", 32'h0, 32'h001, 1);
    send(0, 3, 0, 32'h4000);
    drain("ab_drain");
    rdy_mode = 2;
    send(0, 2, 0, 32'h4100);
    check("ab_held", 32'(M_AXIS_TVALID), 1);
    wr("abort", 32'h0, 32'h002, 0);
    exp_q.delete();
    check("ab_flush", 32'(M_AXIS_TVALID), 0);
    rdy_mode = 0;
    rd_chk("ab_status", 32'h8, 32'h0003_0000);
    repeat (4) @(posedge CLK);
    #1;
    wr("len2", 32'h4, 32'd2, 0);
    wr("start_sel2", 32'h0, 32'h201, 0);
    send(2, 2, 2, 32'h5000);
    drain("post_ab_drain");
    rd_chk("post_ab", 32'h8, 32'h0002_0002);

    // reset mid-job
    rdy_mode = 2;
    wr("len6", 32'h4, 32'd6, 0);
    wr("start_rst", 32'h0, 32'h101, 0);
    send(1, 2, 0, 32'h6000);
    @(posedge CLK); #1;
    RESETN = 1'b0;
    @(posedge CLK); #1;
    RESETN = 1'b1;
    @(negedge CLK);
    check("mr_m_valid", 32'(M_AXIS_TVALID), 0);
    check("mr_m_last", 32'(M_AXIS_TLAST), 0);
    check("mr_rx_ready", 32'(ENG_RX_TREADY), 0);
    check("mr_s_ready", 32'(S_AXIS_TREADY), 0);
    check("mr_tx_valid", 32'(ENG_TX_TVALID), 0);
    check("mr_prdata", PRDATA, 0);
    exp_q.delete();
    rdy_mode = 0;
    repeat (4) @(posedge CLK);
    rd_chk("mr_status", 32'h8, 32'h0);
    rd_chk("mr_len", 32'h4, 32'h0);
    rd_chk("mr_ctrl", 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
